// File: rtl/hs32_regfile_pkg.sv
// hs32 shared register-file types: register index, mode encoding and geometry.
package hs32_types;

    localparam int unsigned HS32_NREGS     = 16;
    localparam int unsigned HS32_BANK_BASE = 12;
    localparam int unsigned HS32_XLEN      = 32;

    typedef logic [3:0] hs32_reg_t;

    typedef enum logic {
        HS32_USER  = 1'b0,
        HS32_SUPER = 1'b1
    } hs32_mode_t;

endpackage

// File: rtl/hs32_regfile_scoreboard.sv
// hs32 pending-write scoreboard: one bit per architectural index, shared by both banks.
// Priority per edge: reset > flush > issue set > write-back clear.
module hs32_scoreboard
    import hs32_types::*;
#(
    parameter int unsigned NREGS = HS32_NREGS,
    parameter int unsigned AW    = $clog2(HS32_NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             flush,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic [NREGS-1:0] pending
);

    logic [NREGS-1:0] pending_nxt;

    // Next pending vector; issue applied after clear so the newer owner wins.
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            if (wr_en) begin
                pending_nxt[wr_addr] = 1'b0;
            end
            if (iss_valid) begin
                pending_nxt[iss_rd] = 1'b1;
            end
        end
    end

    // Pending register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Hazard lookups for the two decode operands.
    always_comb begin
        busy_a = pending[ra_addr];
        busy_b = pending[rb_addr];
    end

endmodule

// File: rtl/hs32_regfile.sv
// hs32 architectural register file: r0..r15, r12..r15 banked by privilege mode,
// three combinational read ports, dual-bank write port and pending-write scoreboard.
// Optional macro HS32_REGFILE_BYPASS_EN: same-cycle write-through forwarding to
// reads that target the active-bank copy being written.
module hs32_regfile
    import hs32_types::*;
#(
    parameter int unsigned NREGS     = HS32_NREGS,
    parameter int unsigned BANK_BASE = HS32_BANK_BASE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode_i,
    input  logic [$clog2(NREGS)-1:0]      ra_addr_i,
    output logic [HS32_XLEN-1:0]          ra_data_o,
    input  logic [$clog2(NREGS)-1:0]      rb_addr_i,
    output logic [HS32_XLEN-1:0]          rb_data_o,
    input  logic [$clog2(NREGS)-1:0]      rp_addr_i,
    output logic [HS32_XLEN-1:0]          rp_data_o,
    input  logic [$clog2(NREGS)-1:0]      wp_addr_i,
    input  logic [HS32_XLEN-1:0]          wp_data_i,
    input  logic                          wp_we1_i,
    input  logic                          wp_we2_i,
    input  logic                          iss_valid_i,
    input  logic [$clog2(NREGS)-1:0]      iss_rd_i,
    input  logic                          flush_i,
    output logic                          busy_a_o,
    output logic                          busy_b_o,
    output logic [NREGS-1:0]              busy_vec_o
);

    localparam int unsigned AW    = $clog2(NREGS);
    localparam int unsigned NBANK = NREGS - BANK_BASE;
    localparam int unsigned BW    = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int unsigned FW    = (BANK_BASE > 1) ? $clog2(BANK_BASE) : 1;
    localparam int unsigned DW    = HS32_XLEN;

    logic [DW-1:0] flat_q [BANK_BASE];
    logic [DW-1:0] user_q [NBANK];
    logic [DW-1:0] sup_q  [NBANK];

    hs32_mode_t mode;
    logic       wp_banked;
    logic       wr_flat;
    logic       wr_user;
    logic       wr_sup;
    logic       sb_busy_a;
    logic       sb_busy_b;

    function automatic logic is_banked(input logic [AW-1:0] a);
        return a >= AW'(BANK_BASE);
    endfunction

    function automatic logic [BW-1:0] bank_idx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - AW'(BANK_BASE);
        return BW'(off);
    endfunction

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a, input hs32_mode_t m);
        if (is_banked(a)) begin
            return (m == HS32_SUPER) ? sup_q[bank_idx(a)] : user_q[bank_idx(a)];
        end
        return flat_q[FW'(a)];
    endfunction

    // Resolve which storage copies the write port touches; we1 = active bank, we2 = alternate.
    always_comb begin
        mode      = hs32_mode_t'(mode_i);
        wp_banked = is_banked(wp_addr_i);
        wr_flat   = !wp_banked && (wp_we1_i || wp_we2_i);
        wr_user   = wp_banked && ((mode == HS32_USER) ? wp_we1_i : wp_we2_i);
        wr_sup    = wp_banked && ((mode == HS32_SUPER) ? wp_we1_i : wp_we2_i);
    end

    // Storage update with synchronous active-low reset overriding any write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(BANK_BASE); i++) begin
                flat_q[i] <= '0;
            end
            for (int i = 0; i < int'(NBANK); i++) begin
                user_q[i] <= '0;
                sup_q[i]  <= '0;
            end
        end else begin
            if (wr_flat) begin
                flat_q[FW'(wp_addr_i)] <= wp_data_i;
            end
            if (wr_user) begin
                user_q[bank_idx(wp_addr_i)] <= wp_data_i;
            end
            if (wr_sup) begin
                sup_q[bank_idx(wp_addr_i)] <= wp_data_i;
            end
        end
    end

    hs32_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid_i),
        .iss_rd    (iss_rd_i),
        .wr_en     (wp_we1_i | wp_we2_i),
        .wr_addr   (wp_addr_i),
        .flush     (flush_i),
        .ra_addr   (ra_addr_i),
        .rb_addr   (rb_addr_i),
        .busy_a    (sb_busy_a),
        .busy_b    (sb_busy_b),
        .pending   (busy_vec_o)
    );

`ifdef HS32_REGFILE_BYPASS_EN
    logic hit_a;
    logic hit_b;
    logic hit_p;

    // A read forwards only when the write lands in the copy that read would see.
    function automatic logic bypass_hit(input logic [AW-1:0] a);
        return (a == wp_addr_i) && (is_banked(a) ? wp_we1_i : (wp_we1_i || wp_we2_i));
    endfunction

    // Read ports with write-through forwarding; forwarded operands are not busy.
    always_comb begin
        hit_a     = bypass_hit(ra_addr_i);
        hit_b     = bypass_hit(rb_addr_i);
        hit_p     = bypass_hit(rp_addr_i);
        ra_data_o = hit_a ? wp_data_i : rd_word(ra_addr_i, mode);
        rb_data_o = hit_b ? wp_data_i : rd_word(rb_addr_i, mode);
        rp_data_o = hit_p ? wp_data_i : rd_word(rp_addr_i, mode);
        busy_a_o  = sb_busy_a && !hit_a;
        busy_b_o  = sb_busy_b && !hit_b;
    end
`else
    // Read ports return stored contents of the active bank only.
    always_comb begin
        ra_data_o = rd_word(ra_addr_i, mode);
        rb_data_o = rd_word(rb_addr_i, mode);
        rp_data_o = rd_word(rp_addr_i, mode);
        busy_a_o  = sb_busy_a;
        busy_b_o  = sb_busy_b;
    end
`endif

endmodule

// File: tb/tb_hs32_regfile.sv
// Directed self-checking bench for hs32_regfile (both bypass builds).
module tb_hs32_regfile;

    logic        clk;
    logic        reset;
    logic        mode_i;
    logic [3:0]  ra_addr_i;
    logic [31:0] ra_data_o;
    logic [3:0]  rb_addr_i;
    logic [31:0] rb_data_o;
    logic [3:0]  rp_addr_i;
    logic [31:0] rp_data_o;
    logic [3:0]  wp_addr_i;
    logic [31:0] wp_data_i;
    logic        wp_we1_i;
    logic        wp_we2_i;
    logic        iss_valid_i;
    logic [3:0]  iss_rd_i;
    logic        flush_i;
    logic        busy_a_o;
    logic        busy_b_o;
    logic [15:0] busy_vec_o;

    int n_checks = 0;
    int n_errors = 0;

    hs32_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .mode_i      (mode_i),
        .ra_addr_i   (ra_addr_i),
        .ra_data_o   (ra_data_o),
        .rb_addr_i   (rb_addr_i),
        .rb_data_o   (rb_data_o),
        .rp_addr_i   (rp_addr_i),
        .rp_data_o   (rp_data_o),
        .wp_addr_i   (wp_addr_i),
        .wp_data_i   (wp_data_i),
        .wp_we1_i    (wp_we1_i),
        .wp_we2_i    (wp_we2_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .flush_i     (flush_i),
        .busy_a_o    (busy_a_o),
        .busy_b_o    (busy_b_o),
        .busy_vec_o  (busy_vec_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wp();
        wp_we1_i = 1'b0;
        wp_we2_i = 1'b0;
    endtask

    initial begin
        reset = 1'b0; mode_i = 1'b0;
        ra_addr_i = '0; rb_addr_i = '0; rp_addr_i = '0;
        wp_addr_i = '0; wp_data_i = '0; wp_we1_i = 1'b0; wp_we2_i = 1'b0;
        iss_valid_i = 1'b0; iss_rd_i = '0; flush_i = 1'b0;

        // Reset for two cycles with a write and an issue pending: reset must win.
        wp_addr_i = 4'd1; wp_data_i = 32'h5555_5555; wp_we1_i = 1'b1;
        iss_valid_i = 1'b1; iss_rd_i = 4'd1;
        tick();
        tick();
        reset = 1'b1;
        idle_wp(); iss_valid_i = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            mode_i = m[0];
            for (int a = 0; a < 16; a++) begin
                ra_addr_i = 4'(a); rb_addr_i = 4'(a); rp_addr_i = 4'(a);
                #1;
                check($sformatf("rst_ra_m%0d_r%0d", m, a), ra_data_o, 32'h0);
                check($sformatf("rst_rb_m%0d_r%0d", m, a), rb_data_o, 32'h0);
                check($sformatf("rst_rp_m%0d_r%0d", m, a), rp_data_o, 32'h0);
            end
        end
        check("rst_busy_vec", 32'(busy_vec_o), 32'h0);
        check("rst_busy_a", 32'(busy_a_o), 32'h0);
        mode_i = 1'b0;

        // r3 write with we1: same-cycle result depends on bypass build.
        wp_addr_i = 4'd3; wp_data_i = 32'hDEAD_BEEF; wp_we1_i = 1'b1;
        ra_addr_i = 4'd3;
        #1;
`ifdef HS32_REGFILE_BYPASS_EN
        check("r3_same_cycle", ra_data_o, 32'hDEAD_BEEF);
`else
        check("r3_same_cycle", ra_data_o, 32'h0);
`endif
        tick();
        idle_wp();
        #1;
        check("r3_next_cycle", ra_data_o, 32'hDEAD_BEEF);

        // Disabled enables with arbitrary address/data leave storage untouched.
        wp_addr_i = 4'd3; wp_data_i = 32'h0BAD_0BAD;
        tick();
        check("r3_gated_off", ra_data_o, 32'hDEAD_BEEF);

        // Banked r13: user and supervisor copies written separately.
        mode_i = 1'b0; wp_addr_i = 4'd13; wp_data_i = 32'h1111; wp_we1_i = 1'b1;
        tick();
        mode_i = 1'b1; wp_data_i = 32'h2222;
        ra_addr_i = 4'd13;
        #1;
`ifdef HS32_REGFILE_BYPASS_EN
        check("r13_sup_same_cycle", ra_data_o, 32'h2222);
`else
        check("r13_sup_same_cycle", ra_data_o, 32'h0);
`endif
        tick();
        idle_wp();
        mode_i = 1'b0; rb_addr_i = 4'd13;
        #1;
        check("r13_user_ra", ra_data_o, 32'h1111);
        check("r13_user_rb", rb_data_o, 32'h1111);
        mode_i = 1'b1;
        #1;
        check("r13_sup_ra", ra_data_o, 32'h2222);
        check("r13_sup_rb", rb_data_o, 32'h2222);

        // we2 from supervisor hits the user copy of r14 and never bypasses.
        mode_i = 1'b1; wp_addr_i = 4'd14; wp_data_i = 32'hABCD; wp_we2_i = 1'b1;
        ra_addr_i = 4'd14;
        #1;
        check("r14_we2_no_bypass", ra_data_o, 32'h0);
        tick();
        idle_wp();
        #1;
        check("r14_sup_untouched", ra_data_o, 32'h0);
        mode_i = 1'b0;
        #1;
        check("r14_user_written", ra_data_o, 32'hABCD);

        // we2 on unbanked r4 writes the single register.
        mode_i = 1'b1; wp_addr_i = 4'd4; wp_data_i = 32'h0404_0404; wp_we2_i = 1'b1;
        tick();
        idle_wp();
        mode_i = 1'b0; rp_addr_i = 4'd4;
        #1;
        check("r4_we2_unbanked", rp_data_o, 32'h0404_0404);

        // Both enables on banked r15 write both copies.
        wp_addr_i = 4'd15; wp_data_i = 32'hF0F0_1515; wp_we1_i = 1'b1; wp_we2_i = 1'b1;
        tick();
        idle_wp();
        rp_addr_i = 4'd15; mode_i = 1'b0;
        #1;
        check("r15_both_user", rp_data_o, 32'hF0F0_1515);
        mode_i = 1'b1;
        #1;
        check("r15_both_sup", rp_data_o, 32'hF0F0_1515);
        mode_i = 1'b0;

        // Scoreboard: issue sets, issue+write keeps set, write alone clears next cycle.
        iss_valid_i = 1'b1; iss_rd_i = 4'd5;
        tick();
        iss_valid_i = 1'b0;
        ra_addr_i = 4'd5; rb_addr_i = 4'd6;
        #1;
        check("sb_set5_vec", 32'(busy_vec_o), 32'h0000_0020);
        check("sb_set5_busy_a", 32'(busy_a_o), 32'h1);
        check("sb_set5_busy_b", 32'(busy_b_o), 32'h0);
        iss_valid_i = 1'b1; iss_rd_i = 4'd5;
        wp_addr_i = 4'd5; wp_data_i = 32'h55; wp_we1_i = 1'b1;
        tick();
        iss_valid_i = 1'b0; idle_wp();
        #1;
        check("sb_set_wins", 32'(busy_vec_o), 32'h0000_0020);
        wp_addr_i = 4'd5; wp_data_i = 32'h56; wp_we1_i = 1'b1;
        #1;
        check("sb_clear_not_yet", 32'(busy_vec_o), 32'h0000_0020);
`ifdef HS32_REGFILE_BYPASS_EN
        check("sb_busy_a_bypassed", 32'(busy_a_o), 32'h0);
`else
        check("sb_busy_a_still", 32'(busy_a_o), 32'h1);
`endif
        tick();
        idle_wp();
        #1;
        check("sb_cleared", 32'(busy_vec_o), 32'h0);
        check("sb_cleared_busy_a", 32'(busy_a_o), 32'h0);
        check("r5_data", ra_data_o, 32'h56);

        // Flush drops pending bits and a same-cycle issue.
        iss_valid_i = 1'b1; iss_rd_i = 4'd7;
        tick();
        iss_rd_i = 4'd9;
        tick();
        iss_valid_i = 1'b0;
        #1;
        check("sb_7_9", 32'(busy_vec_o), 32'h0000_0280);
        flush_i = 1'b1; iss_valid_i = 1'b1; iss_rd_i = 4'd2;
        tick();
        flush_i = 1'b0; iss_valid_i = 1'b0;
        #1;
        check("sb_flush", 32'(busy_vec_o), 32'h0);

        // Reset with bits pending clears scoreboard and storage.
        iss_valid_i = 1'b1; iss_rd_i = 4'd7;
        tick();
        iss_rd_i = 4'd9;
        tick();
        iss_valid_i = 1'b0;
        #1;
        check("sb_prereset", 32'(busy_vec_o), 32'h0000_0280);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ra_addr_i = 4'd3; rb_addr_i = 4'd9; mode_i = 1'b0;
        #1;
        check("sb_after_reset", 32'(busy_vec_o), 32'h0);
        check("busy_b_after_reset", 32'(busy_b_o), 32'h0);
        check("r3_after_reset", ra_data_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hs32_regfile.md
Name: hs32_regfile

Overview:
- Architectural register file for the hs32 core; the responder to the execute stage's regfile read and write ports, and to the decode stage's operand reads.
- Holds r0–r15 at 32 bits each. r12–r15 are banked between user mode and supervisor mode.
- Contains a pending-write scoreboard that decode uses to detect read-after-write hazards and request stalls or forwarding.

Parameters:
- NREGS, 16, number of architectural registers; the address width is clog2(NREGS).
- BANK_BASE, 12, lowest banked register index; registers BANK_BASE..NREGS-1 are duplicated per mode.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- mode_i  in  1  current privilege: 0 = user, 1 = supervisor. Selects the active bank.
- ra_addr_i  in  4  decode operand A read address.
- ra_data_o  out  32  operand A data, active bank.
- rb_addr_i  in  4  decode operand B read address.
- rb_data_o  out  32  operand B data, active bank.
- rp_addr_i  in  4  execute store-data read address.
- rp_data_o  out  32  store data, active bank.
- wp_addr_i  in  4  write address.
- wp_data_i  in  32  write data.
- wp_we1_i  in  1  write enable for the active bank (bank selected by mode_i).
- wp_we2_i  in  1  write enable for the alternate bank (bank selected by !mode_i).
- iss_valid_i  in  1  an instruction that writes rd is being issued this cycle.
- iss_rd_i  in  4  destination register of the issuing instruction.
- flush_i  in  1  clear all scoreboard pending bits.
- busy_a_o  out  1  ra_addr_i has a pending write.
- busy_b_o  out  1  rb_addr_i has a pending write.
- busy_vec_o  out  16  raw scoreboard pending bits.

Behaviour:
- Storage:
  - 12 unbanked registers.
  - 4 user-bank registers and 4 supervisor-bank registers for indices 12–15.
- Reset (reset==0 at a clk edge):
  - all 20 storage words go to 32'h0 and all pending bits go to 0.
  - The cycle after reset, every read output is 32'h0 and busy_a_o, busy_b_o and busy_vec_o are all 0.
  - Reset overrides any simultaneous write, issue or flush.
- Reads:
  - Combinational, zero latency, from the bank selected by mode_i.
  - An unbanked address ignores mode.
- Writes:
  - Take effect at the clk edge and are visible on the read outputs in the next cycle. Same-cycle behaviour is covered under the optional feature.
  - wp_we1_i writes the active bank; wp_we2_i writes the alternate bank.
  - For an unbanked address, we1 alone, we2 alone or both together all write the single register once with the same data.
  - For a banked address with both enables set, both bank copies receive wp_data_i.
- Scoreboard:
  - Bit n is set at the clk edge when iss_valid_i is high and iss_rd_i == n.
  - Bit n is cleared at the clk edge when (wp_we1_i | wp_we2_i) is high and wp_addr_i == n.
  - Set and clear on the same index in the same cycle: set wins, because the newer issue owns the register.
  - flush_i clears every bit, overriding a same-cycle clear. A same-cycle issue is dropped, since flush discards in-flight instructions.
  - busy_a_o = pending[ra_addr_i] and busy_b_o = pending[rb_addr_i], both combinational.
  - A write in the current cycle does not clear busy until the next cycle.
- Mode change:
  - Takes effect on reads immediately when mode_i toggles.
  - The scoreboard is not banked: one pending bit per architectural index, shared by both banks.
- X-safety: write enables gated off have no effect regardless of the address or data values.

Optional Feature:
- Macro: HS32_REGFILE_BYPASS_EN.
- Defined:
  - Each read port compares its address against wp_addr_i. On a match, with the enable targeting the active bank, it returns wp_data_i in the same cycle (write-through forwarding).
  - For a banked index, a we2-only write does not bypass, because it targets the inactive bank.
  - busy_a_o and busy_b_o are suppressed in the same cycle for an address being written and bypassed.
- Undefined: no bypass; reads return stored contents only, so write data appears one cycle later.

Decomposition:
- Shared package hs32_types:
  - typedef hs32_reg_t (logic[3:0]).
  - constants HS32_NREGS = 16 and HS32_BANK_BASE = 12.
  - enum hs32_mode_t {HS32_USER = 0, HS32_SUPER = 1}.
- One sub-module, hs32_scoreboard: the pending-bit vector with set/clear/flush priority and the two busy lookups.

Test Plan:
- Reset low for 2 cycles, then release → all three read ports return 0 for addresses 0–15 and busy_vec_o == 16'h0.
- Write r3 = 32'hDEADBEEF with we1, then read ra=3 next cycle → 32'hDEADBEEF. With bypass enabled, the same cycle also returns 32'hDEADBEEF.
- mode=0, write r13 = 32'h1111 (we1); mode=1, write r13 = 32'h2222 (we1). Then read r13 with mode=0 → 32'h1111, and with mode=1 → 32'h2222.
- mode=1, we2 write r14 = 32'hABCD → supervisor r14 stays 0 and user r14 (mode=0 read) returns 32'hABCD. With bypass enabled, there is no same-cycle bypass.
- Issue rd=5 → busy_vec_o[5] = 1 next cycle. Then, in the same cycle, issue rd=5 and write r5 → bit 5 stays 1. Then write r5 alone → bit 5 clears.
- Issue rd=7 and rd=9 on consecutive cycles, then flush together with issue rd=2 → busy_vec_o == 16'h0. Then assert reset while bits are pending → all clear.
